tri_bus_driver: RTL and testbench
=================================

TRI_BUS_DRIVER -- requirements
Module: tri_bus_driver

Interface
REQ-001 SHALL have parameter: width, 1, data width of each driver port.
REQ-002 SHALL have parameter: turn, 1, bus-turnaround cycles (legal 1..15) with no driver enabled between owners.
REQ-003 SHALL have parameter: maxhold, 16, ownership cycle limit (legal 2..255); used only when TRIBUS_TIMEOUT_EN is defined.
REQ-004 SHALL have port: CLK  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port: RST_N  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports: REQ_0 / REQ_1  input  1  bus ownership request from client 0/1, level-held.
REQ-007 SHALL have ports: IN_0 / IN_1  input  width  data client 0/1 places on the bus.
REQ-008 SHALL have ports: GNT_0 / GNT_1  output  1  registered ownership grant to client 0/1.
REQ-009 SHALL have ports: OE_0 / OE_1  output  1  registered driver enable, equal to GNT_x.
REQ-010 SHALL have ports: OUT_0 / OUT_1  output (tri)  width  IN_x when OE_x=1, else all-Z; intended to feed a two-input tri-state resolver.

Function
REQ-011 SHALL implement FSM states IDLE, OWN0, OWN1, TURN.
REQ-012 SHALL, in IDLE with exactly one REQ_x high, enter OWNx next edge; GNT_x/OE_x high from that cycle (1-cycle request-to-grant latency).
REQ-013 SHALL, in IDLE with both REQ high, grant the port not granted most recently (round-robin pointer; pointer after reset favours port 0).
REQ-014 SHALL remain in OWNx while REQ_x=1 (subject to REQ-020); other REQ is ignored.
REQ-015 SHALL, in OWNx with REQ_x sampled low, enter TURN next edge; GNT_x/OE_x drop that same edge; pointer records x.
REQ-016 SHALL stay in TURN exactly `turn` cycles (down-counter loaded with turn-1), then enter IDLE; grants resume per REQ-012/013 one cycle later.
REQ-017 SHALL never assert OE_0 and OE_1 in the same cycle, and SHALL never transition OWN0<->OWN1 directly.
REQ-018 SHALL keep OUT_0/OUT_1 all-Z in IDLE and TURN.
REQ-019 SHALL treat a REQ_x pulse withdrawn before grant as lost (no queued request).

Configuration
REQ-020 SHALL, with TRIBUS_TIMEOUT_EN defined, count cycles in OWNx (8-bit counter, cleared on entry) and force OWNx->TURN when count reaches maxhold-1 while the other REQ is high; pointer records x so the other port wins next.
REQ-021 SHALL, with TRIBUS_TIMEOUT_EN undefined, contain no hold counter and grant ownership indefinitely while REQ_x is high.

Reset
REQ-022 SHALL, on any edge with RST_N=0, including mid-OWN or mid-TURN, go to IDLE, clear GNT_0/GNT_1/OE_0/OE_1 to 0, counters to 0, pointer to favour port 0; OUT_0/OUT_1 all-Z the following cycle.

Structure
REQ-023 SHALL place FSM state encoding constants and counter widths in shared package tribus_pkg.
REQ-024 SHALL implement the arbitration decision in one sub-module, tribus_rr_pick (inputs REQ_0, REQ_1, pointer; outputs one-hot pick).

Verification (width=8, turn=2, maxhold=4)
REQ-025 SHALL verify: REQ_0=1, IN_0=0xA5 at cycle 0 from IDLE -> GNT_0=OE_0=1, OUT_0=0xA5 at cycle 1; OUT_1 all-Z throughout.
REQ-026 SHALL verify: REQ_0=REQ_1=1 after reset -> port 0 granted; REQ_0 dropped -> 2 TURN cycles both Z, 1 IDLE cycle, then GNT_1=1.
REQ-027 SHALL verify: both REQ held, each owner releasing after 3 cycles -> grants alternate 0,1,0,1 with >=2 idle-bus cycles between owners.
REQ-028 SHALL verify, TRIBUS_TIMEOUT_EN defined: REQ_0 held, REQ_1 raised -> GNT_0 drops after 4 owned cycles, GNT_1 rises 3 cycles later; undefined -> GNT_0 held for 50 cycles.
REQ-029 SHALL verify: RST_N=0 for one cycle during OWN1 -> next cycle GNT/OE all 0, OUT_1 all-Z, subsequent simultaneous REQ grants port 0.
REQ-030 SHALL verify by assertion over random REQ stimulus: OE_0&OE_1 never 1, and each OE rise is preceded by >=turn cycles with both OE low.

Source files
------------

// File: rtl/tribus_pkg.sv
// Shared definitions for the two-client tri-state bus driver: FSM encoding and counter widths.
package tribus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_TURN = 2'd3
    } state_e;

    localparam int TURN_CNT_W = 4;
    localparam int HOLD_CNT_W = 8;

    localparam logic [HOLD_CNT_W-1:0] HOLD_CNT_MAX = '1;

endpackage

// File: rtl/tribus_rr_pick.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the favoured port.
module tribus_rr_pick (
    input  logic       REQ_0,
    input  logic       REQ_1,
    input  logic       pointer,
    output logic [1:0] pick
);

    // pointer = 1 favours port 1, pointer = 0 favours port 0
    assign pick = (REQ_0 && REQ_1) ? (pointer ? 2'b10 : 2'b01) : {REQ_1, REQ_0};

endmodule

// File: rtl/tri_bus_driver.sv
// Arbitrated pair of tri-state drivers with a guaranteed dead-bus turnaround between owners.
// Optional ownership time limit enabled by defining TRIBUS_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | bus released, arbitrating pending requests
//   OWN0  | client 0 drives OUT_0
//   OWN1  | client 1 drives OUT_1
//   TURN  | turnaround, no driver enabled for `turn` cycles
module tri_bus_driver
    import tribus_pkg::*;
#(
    parameter int width   = 1,
    parameter int turn    = 1,
    parameter int maxhold = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ_0,
    input  logic             REQ_1,
    input  logic [width-1:0] IN_0,
    input  logic [width-1:0] IN_1,
    output logic             GNT_0,
    output logic             GNT_1,
    output logic             OE_0,
    output logic             OE_1,
    output tri   [width-1:0] OUT_0,
    output tri   [width-1:0] OUT_1
);

    if (turn < 1 || turn > 15) begin : g_bad_turn
        $error("tri_bus_driver: turn must be 1..15");
    end
    if (maxhold < 2 || maxhold > 255) begin : g_bad_maxhold
        $error("tri_bus_driver: maxhold must be 2..255");
    end

    localparam logic [TURN_CNT_W-1:0] TURN_LOAD = TURN_CNT_W'(turn - 1);

    state_e                state_q, state_d;
    logic [TURN_CNT_W-1:0] tcnt_q, tcnt_d;
    logic                  prio_q, prio_d;
    logic [1:0]            pick;
    logic                  own_req;
    logic                  expire;

`ifdef TRIBUS_TIMEOUT_EN
    localparam logic [HOLD_CNT_W-1:0] HOLD_LIMIT = HOLD_CNT_W'(maxhold - 1);
    logic [HOLD_CNT_W-1:0] hold_q, hold_d;
    logic                  oth_req;
`endif

    tribus_rr_pick u_pick (
        .REQ_0   (REQ_0),
        .REQ_1   (REQ_1),
        .pointer (prio_q),
        .pick    (pick)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            prio_q  <= 1'b0;
`ifdef TRIBUS_TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            prio_q  <= prio_d;
`ifdef TRIBUS_TIMEOUT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        prio_d  = prio_q;
        own_req = (state_q == ST_OWN0) ? REQ_0 : REQ_1;
        expire  = 1'b0;
`ifdef TRIBUS_TIMEOUT_EN
        hold_d  = hold_q;
        oth_req = (state_q == ST_OWN0) ? REQ_1 : REQ_0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef TRIBUS_TIMEOUT_EN
                hold_d = '0;
`endif
                if (pick[0]) begin
                    state_d = ST_OWN0;
                end else if (pick[1]) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
`ifdef TRIBUS_TIMEOUT_EN
                // saturate so a late competing request still sees the limit
                expire = oth_req && (hold_q >= HOLD_LIMIT);
                hold_d = (hold_q == HOLD_CNT_MAX) ? hold_q : hold_q + 1'b1;
`endif
                if (!own_req || expire) begin
                    state_d = ST_TURN;
                    tcnt_d  = TURN_LOAD;
                    prio_d  = (state_q == ST_OWN0);
                end
            end
            ST_TURN: begin
                if (tcnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign GNT_0 = (state_q == ST_OWN0);
    assign GNT_1 = (state_q == ST_OWN1);
    assign OE_0  = GNT_0;
    assign OE_1  = GNT_1;

    assign OUT_0 = OE_0 ? IN_0 : {width{1'bz}};
    assign OUT_1 = OE_1 ? IN_1 : {width{1'bz}};

endmodule

// File: tb/tb_tri_bus_driver.sv
// Self-checking bench for tri_bus_driver: directed scenarios plus random requests against a cycle model.
module tb_tri_bus_driver;

    localparam int W       = 8;
    localparam int TURN    = 2;
    localparam int MAXHOLD = 4;

    logic         CLK   = 1'b0;
    logic         RST_N = 1'b0;
    logic         REQ_0 = 1'b0;
    logic         REQ_1 = 1'b0;
    logic [W-1:0] IN_0  = 8'h11;
    logic [W-1:0] IN_1  = 8'h22;
    logic         GNT_0, GNT_1, OE_0, OE_1;
    wire  [W-1:0] OUT_0, OUT_1;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: current owner (-1 none), quiet cycles left, favoured port, owned cycles
    int m_owner = -1;
    int m_wait  = 0;
    int m_fav   = 0;
    int m_held  = 0;

    int   lowrun   = TURN;
    logic prev_oe0 = 1'b0;
    logic prev_oe1 = 1'b0;
    int   idle;
    int   n;

    always #5 CLK = ~CLK;

    tri_bus_driver #(.width(W), .turn(TURN), .maxhold(MAXHOLD)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .REQ_0 (REQ_0),
        .REQ_1 (REQ_1),
        .IN_0  (IN_0),
        .IN_1  (IN_1),
        .GNT_0 (GNT_0),
        .GNT_1 (GNT_1),
        .OE_0  (OE_0),
        .OE_1  (OE_1),
        .OUT_0 (OUT_0),
        .OUT_1 (OUT_1)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // a released driver reads Z in a 4-state simulator; in any case it must not carry IN (kept nonzero)
    function automatic logic released(input logic [W-1:0] o, input logic [W-1:0] i);
        return (o === {W{1'bz}}) || (o !== i);
    endfunction

    function automatic logic [W-1:0] rnd_data();
        return W'($urandom_range(1, 255));
    endfunction

    task automatic model_edge();
        logic mine, other, tmo;
        if (!RST_N) begin
            m_owner = -1; m_wait = 0; m_fav = 0; m_held = 0;
        end else if (m_owner >= 0) begin
            mine  = (m_owner == 0) ? REQ_0 : REQ_1;
            other = (m_owner == 0) ? REQ_1 : REQ_0;
            tmo   = 1'b0;
`ifdef TRIBUS_TIMEOUT_EN
            tmo   = other && (m_held >= MAXHOLD);
`endif
            if (!mine || tmo) begin
                m_fav   = 1 - m_owner;
                m_owner = -1;
                m_wait  = TURN;
            end else begin
                m_held++;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (REQ_0 && REQ_1) begin
            m_owner = m_fav; m_held = 1;
        end else if (REQ_0) begin
            m_owner = 0; m_held = 1;
        end else if (REQ_1) begin
            m_owner = 1; m_held = 1;
        end
    endtask

    task automatic tick();
        logic rst_seen;
        @(posedge CLK);
        rst_seen = !RST_N;
        model_edge();
        #1;
        chk("gnt0", GNT_0, m_owner == 0);
        chk("gnt1", GNT_1, m_owner == 1);
        chk("oe0", OE_0, m_owner == 0);
        chk("oe1", OE_1, m_owner == 1);
        if (m_owner == 0) chk("out0_drv", {24'b0, OUT_0}, {24'b0, IN_0});
        else              chk("out0_z", released(OUT_0, IN_0), 1);
        if (m_owner == 1) chk("out1_drv", {24'b0, OUT_1}, {24'b0, IN_1});
        else              chk("out1_z", released(OUT_1, IN_1), 1);
        chk("oe_excl", OE_0 & OE_1, 0);
        if (OE_0 && !prev_oe0) chk("gap_oe0", lowrun >= TURN, 1);
        if (OE_1 && !prev_oe1) chk("gap_oe1", lowrun >= TURN, 1);
        lowrun   = (!OE_0 && !OE_1) ? lowrun + 1 : 0;
        if (rst_seen) lowrun = TURN;
        prev_oe0 = OE_0;
        prev_oe1 = OE_1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
    endtask

    initial begin
        IN_0 = rnd_data();
        IN_1 = rnd_data();
        #1;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_gnt", {GNT_1, GNT_0, OE_1, OE_0}, 4'b0000);
        RST_N = 1'b1;
        tick();

        // single request, one cycle to grant
        REQ_0 = 1'b1; IN_0 = 8'hA5;
        tick();
        chk("single_gnt0", GNT_0, 1);
        chk("single_oe0", OE_0, 1);
        chk("single_out0", {24'b0, OUT_0}, 32'hA5);
        for (int i = 0; i < 3; i++) tick();
        REQ_0 = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // tie after reset goes to port 0, then turnaround before port 1
        do_reset();
        REQ_0 = 1'b1; REQ_1 = 1'b1;
        tick();
        chk("tie_gnt0", {GNT_1, GNT_0}, 2'b01);
        tick();
        REQ_0 = 1'b0;
        tick();
        chk("turn1_oe", {OE_1, OE_0}, 2'b00);
        tick();
        chk("turn2_oe", {OE_1, OE_0}, 2'b00);
        tick();
        chk("idle_gnt", {GNT_1, GNT_0}, 2'b00);
        tick();
        chk("after_turn_gnt1", {GNT_1, GNT_0}, 2'b10);
        REQ_1 = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // alternation with both requesting, each owner releasing after 3 cycles
        REQ_0 = 1'b1; REQ_1 = 1'b1;
        idle = 0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 12 && !(GNT_0 || GNT_1); i++) begin
                tick();
                if (!(GNT_0 || GNT_1)) idle++;
            end
            chk("rr_grant", GNT_0 | GNT_1, 1);
            chk("rr_owner", {31'b0, GNT_1}, k % 2);
            if (k > 0) chk("rr_gap", idle >= TURN, 1);
            tick();
            tick();
            if (k % 2 == 0) REQ_0 = 1'b0; else REQ_1 = 1'b0;
            tick();
            idle = (GNT_0 || GNT_1) ? 0 : 1;
            REQ_0 = 1'b1; REQ_1 = 1'b1;
        end
        REQ_0 = 1'b0; REQ_1 = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // ownership limit
        do_reset();
        REQ_0 = 1'b1;
        tick();
        REQ_1 = 1'b1;
`ifdef TRIBUS_TIMEOUT_EN
        n = 0;
        while (GNT_0 && n < 20) begin
            n++;
            tick();
        end
        chk("tmo_owned", n, MAXHOLD);
        n = 0;
        while (!GNT_1 && n < 20) begin
            tick();
            n++;
        end
        chk("tmo_gnt1_delay", n, 3);
`else
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("hold_gnt0", GNT_0, 1);
        end
`endif
        REQ_0 = 1'b0; REQ_1 = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // reset in the middle of OWN1
        do_reset();
        REQ_1 = 1'b1; IN_1 = rnd_data();
        tick();
        tick();
        chk("own1_before_rst", GNT_1, 1);
        RST_N = 1'b0;
        tick();
        chk("mid_rst_outs", {GNT_1, GNT_0, OE_1, OE_0}, 4'b0000);
        chk("mid_rst_out1_z", released(OUT_1, IN_1), 1);
        RST_N = 1'b1;
        REQ_0 = 1'b1;
        tick();
        chk("post_rst_tie", {GNT_1, GNT_0}, 2'b01);
        REQ_0 = 1'b0; REQ_1 = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // random requests against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) REQ_0 = ~REQ_0;
            if ($urandom_range(0, 3) == 0) REQ_1 = ~REQ_1;
            IN_0 = rnd_data();
            IN_1 = rnd_data();
            tick();
        end
        REQ_0 = 1'b0; REQ_1 = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
